// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory mux and the RAM responder.
interface mem_responder_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    // Initiator side: core control unit / datapath
    modport master (
        output mem_rd, mem_wr, addr, wdata, wstrb,
        input  rdata, ready, err, busy
    );

    // Responder side: RAM front-end
    modport slave (
        input  mem_rd, mem_wr, addr, wdata, wstrb,
        output rdata, ready, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: captures a request, waits WAIT_CYCLES, then performs
// the RAM access and emits a one-cycle ready (optionally qualified by err).
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_responder_if.slave bus
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W      = 4;
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rd;
        logic        wr;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    req_t              req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    logic [32:0]       offset_c;
    logic [IDX_W-1:0]  idx_c;
    logic              err_c;
    logic              resp_entry_c;
    logic              wr_commit_c;

    // Sequencing: accept in IDLE, count wait states, single-cycle RESP
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.mem_rd || bus.mem_wr) begin
                    req_d.addr  = bus.addr;
                    req_d.wdata = bus.wdata;
                    req_d.wstrb = bus.wstrb;
                    req_d.rd    = bus.mem_rd;
                    req_d.wr    = bus.mem_wr;
                    cnt_d       = '0;
                    state_d     = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == WAIT_LAST) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode the captured request: word index and rejection conditions
    always_comb begin
        offset_c = {1'b0, req_d.addr} - {1'b0, BASE_ADDR};
        idx_c    = offset_c[IDX_W+1:2];
        err_c    = (req_d.addr[1:0] != 2'b00)
                || offset_c[32]
                || (offset_c >= SPAN_BYTES)
                || (req_d.rd && req_d.wr);
    end

    // Response outputs and array access happen on the edge entering RESP
    always_comb begin
        resp_entry_c = (state_d == S_RESP) && (state_q != S_RESP);
        ready_d      = (state_d == S_RESP);
        err_d        = ready_d && err_c;
        busy_d       = (state_d != S_IDLE);
        rdata_d      = rdata_q;
        if (resp_entry_c) begin
            if (err_c) begin
                rdata_d = '0;
            end else if (req_d.rd) begin
                rdata_d = mem_q[idx_c];
            end
        end
        wr_commit_c  = resp_entry_c && !err_c && req_d.wr;
    end

    // Control and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM byte-lane writes; contents survive reset, reset edge blocks commit
    always_ff @(posedge clk) begin
        if (rst_n && wr_commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (req_d.wstrb[b]) begin
                    mem_q[idx_c][8*b +: 8] <= req_d.wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at WAIT_CYCLES of 0, 1 and 3.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_responder_if b0 ();
    mem_responder_if b1 ();
    mem_responder_if b3 ();

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000_0000))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        case (sel)
            0: begin b0.mem_rd = rd; b0.mem_wr = wr; b0.addr = a; b0.wdata = d; b0.wstrb = s; end
            1: begin b1.mem_rd = rd; b1.mem_wr = wr; b1.addr = a; b1.wdata = d; b1.wstrb = s; end
            default: begin b3.mem_rd = rd; b3.mem_wr = wr; b3.addr = a; b3.wdata = d; b3.wstrb = s; end
        endcase
    endtask

    task automatic sample(input int sel, output logic rdy, output logic er, output logic bsy,
                          output logic [31:0] rd);
        case (sel)
            0: begin rdy = b0.ready; er = b0.err; bsy = b0.busy; rd = b0.rdata; end
            1: begin rdy = b1.ready; er = b1.err; bsy = b1.busy; rd = b1.rdata; end
            default: begin rdy = b3.ready; er = b3.err; bsy = b3.busy; rd = b3.rdata; end
        endcase
    endtask

    // Counts negedges until ready; hs_ok drops if busy falls or err shows without ready
    task automatic wait_resp(input int sel, output int lat, output logic er, output logic [31:0] rdat,
                             output logic hs_ok);
        logic r, e, b;
        logic [31:0] d;
        lat = 0; er = 1'b0; rdat = '0; hs_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            sample(sel, r, e, b, d);
            if (!b || (e && !r)) hs_ok = 1'b0;
            if (r) begin
                lat = n; er = e; rdat = d;
                break;
            end
        end
    endtask

    task automatic txn(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output int lat, output logic er, output logic [31:0] rdat, output logic hs_ok);
        drive(sel, rd, wr, a, d, s);
        wait_resp(sel, lat, er, rdat, hs_ok);
        drive(sel, 1'b0, 1'b0, a, d, s);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic r, e, b;
        logic [31:0] d;
        rst_n = 1'b0;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s += 1 + (s == 1 ? 1 : 0)) begin
            sample(s, r, e, b, d);
            checks++;
            if ({r, e, b} !== 3'b000 || d !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got rdy/err/busy=%b rdata=%h expected 000 rdata=00000000", s, {r, e, b}, d);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int lat; logic er, ok, r, e, b; logic [31:0] d;
        txn(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, er, d, ok);
        checks++;
        if (lat !== 2 || er !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL basic_wr: got lat=%0d err=%b hs=%b expected lat=2 err=0 hs=1", lat, er, ok);
        end
        txn(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (lat !== 2 || er !== 1'b0 || ok !== 1'b1 || d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_rd: got lat=%0d err=%b hs=%b rdata=%h expected lat=2 err=0 hs=1 rdata=deadbeef", lat, er, ok, d);
        end
        sample(1, r, e, b, d);
        checks++;
        if ({r, e, b} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle: got rdy/err/busy=%b expected 000", {r, e, b});
        end
    endtask

    task automatic test_strobes();
        int lat; logic er, ok, r, e, b; logic [31:0] d;
        txn(1, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, er, d, ok);
        txn(1, 1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, er, d, ok);
        checks++;
        if (er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL strobe_wr: got lat=%0d err=%b expected lat=2 err=0", lat, er);
        end
        txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (d !== 32'h11BB_33DD || er !== 1'b0) begin
            errors++;
            $display("FAIL strobe_rd: got rdata=%h err=%b expected 11bb33dd err=0", d, er);
        end
        txn(1, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, lat, er, d, ok);
        sample(1, r, e, b, d);
        checks++;
        if (er !== 1'b0 || lat !== 2 || d !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_zero_wr: got lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=11bb33dd", lat, er, d);
        end
        txn(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (d !== 32'h11BB_33DD) begin
            errors++;
            $display("FAIL strobe_zero_rd: got rdata=%h expected 11bb33dd", d);
        end
    endtask

    task automatic test_errors();
        int lat; logic er, ok; logic [31:0] d;
        txn(1, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (lat !== 2 || er !== 1'b1 || d !== 32'h0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL err_misalign: got lat=%0d err=%b rdata=%h hs=%b expected lat=2 err=1 rdata=0 hs=1", lat, er, d, ok);
        end
        txn(1, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, lat, er, d, ok);
        txn(1, 1'b0, 1'b1, 32'h1000, 32'h0BAD_BEEF, 4'hF, lat, er, d, ok);
        checks++;
        if (er !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL err_range_wr: got lat=%0d err=%b expected lat=2 err=1", lat, er);
        end
        txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (d !== 32'hCAFE_F00D || er !== 1'b0) begin
            errors++;
            $display("FAIL err_range_nowrite: got rdata=%h err=%b expected cafef00d err=0", d, er);
        end
        txn(1, 1'b1, 1'b1, 32'h0, 32'h0, 4'hF, lat, er, d, ok);
        checks++;
        if (er !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL err_rd_and_wr: got err=%b rdata=%h expected err=1 rdata=0", er, d);
        end
        txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (d !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL err_both_nowrite: got rdata=%h expected cafef00d", d);
        end
        txn(1, 1'b0, 1'b1, 32'hFFC, 32'h0102_0304, 4'hF, lat, er, d, ok);
        txn(1, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (d !== 32'h0102_0304 || er !== 1'b0) begin
            errors++;
            $display("FAIL last_word: got rdata=%h err=%b expected 01020304 err=0", d, er);
        end
    endtask

    task automatic test_wait_cycles();
        int lat; logic er, ok; logic [31:0] d;
        txn(0, 1'b0, 1'b1, 32'h8, 32'h0000_0A0A, 4'hF, lat, er, d, ok);
        checks++;
        if (lat !== 1 || er !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL w0_wr: got lat=%0d err=%b hs=%b expected lat=1 err=0 hs=1", lat, er, ok);
        end
        txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (lat !== 1 || d !== 32'h0000_0A0A || ok !== 1'b1) begin
            errors++;
            $display("FAIL w0_rd: got lat=%0d rdata=%h hs=%b expected lat=1 rdata=00000a0a hs=1", lat, d, ok);
        end
        txn(3, 1'b0, 1'b1, 32'h1000_0004, 32'h3333_0003, 4'hF, lat, er, d, ok);
        checks++;
        if (lat !== 4 || er !== 1'b0 || ok !== 1'b1) begin
            errors++;
            $display("FAIL w3_wr: got lat=%0d err=%b hs=%b expected lat=4 err=0 hs=1", lat, er, ok);
        end
        txn(3, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (lat !== 4 || d !== 32'h3333_0003 || ok !== 1'b1) begin
            errors++;
            $display("FAIL w3_rd: got lat=%0d rdata=%h hs=%b expected lat=4 rdata=33330003 hs=1", lat, d, ok);
        end
        txn(3, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (er !== 1'b1 || d !== 32'h0) begin
            errors++;
            $display("FAIL w3_below_base: got err=%b rdata=%h expected err=1 rdata=0", er, d);
        end
        txn(3, 1'b1, 1'b0, 32'h1000_0400, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL w3_above_top: got err=%b expected 1", er);
        end
    endtask

    task automatic test_back_to_back();
        int lat, sel, w; logic er, ok, r, e, b; logic [31:0] d, a, exp;
        for (int k = 0; k < 2; k++) begin
            sel = (k == 0) ? 0 : 3;
            w   = (k == 0) ? 0 : 3;
            a   = (k == 0) ? 32'h8 : 32'h1000_0004;
            exp = (k == 0) ? 32'h0000_0A0A : 32'h3333_0003;
            drive(sel, 1'b1, 1'b0, a, 32'h0, 4'h0);
            wait_resp(sel, lat, er, d, ok);
            checks++;
            if (lat !== w + 1 || d !== exp || ok !== 1'b1) begin
                errors++;
                $display("FAIL b2b_first[%0d]: got lat=%0d rdata=%h hs=%b expected lat=%0d rdata=%h hs=1", sel, lat, d, ok, w + 1, exp);
            end
            @(negedge clk);
            sample(sel, r, e, b, d);
            checks++;
            if ({r, e, b} !== 3'b000) begin
                errors++;
                $display("FAIL b2b_gap[%0d]: got rdy/err/busy=%b expected 000", sel, {r, e, b});
            end
            wait_resp(sel, lat, er, d, ok);
            checks++;
            if (lat !== w + 1 || d !== exp || ok !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second[%0d]: got lat=%0d rdata=%h hs=%b expected lat=%0d rdata=%h hs=1", sel, lat, d, ok, w + 1, exp);
            end
            drive(sel, 1'b0, 1'b0, a, 32'h0, 4'h0);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic er, ok, r, e, b, seen; logic [31:0] d;
        txn(1, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'hF, lat, er, d, ok);
        drive(1, 1'b0, 1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF);
        @(negedge clk);
        sample(1, r, e, b, d);
        checks++;
        if (r !== 1'b0 || b !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wait: got rdy=%b busy=%b expected rdy=0 busy=1", r, b);
        end
        rst_n = 1'b0;
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
        sample(1, r, e, b, d);
        checks++;
        if ({r, e, b} !== 3'b000 || d !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_abort: got rdy/err/busy=%b rdata=%h expected 000 rdata=0", {r, e, b}, d);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            sample(1, r, e, b, d);
            if (r) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_noready: got ready pulse=%b expected 0", seen);
        end
        txn(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, er, d, ok);
        checks++;
        if (d !== 32'h1234_5678 || lat !== 2) begin
            errors++;
            $display("FAIL rst_mid_contents: got rdata=%h lat=%0d expected 12345678 lat=2", d, lat);
        end
    endtask

    task automatic test_addr_change();
        int lat; logic er, ok; logic [31:0] d;
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_resp(1, lat, er, d, ok);
        drive(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (d !== 32'hDEAD_BEEF || lat !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL addr_change: got rdata=%h rem_lat=%0d err=%b expected deadbeef rem_lat=1 err=0", d, lat, er);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_errors();
        test_wait_cycles();
        test_back_to_back();
        test_reset_mid_op();
        test_addr_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
